// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: phased signal heads with latched requests, min/gap/max green, all-red clearance and round-robin service
package light_package;
  typedef enum logic [1:0] {RED, YELLOW, GREEN} colors;
endpackage

module traffic_phase_controller
  import light_package::*;
#(
  parameter int NUM_LANES = 5,
  parameter int NUM_PHASES = 3,
  parameter logic [NUM_PHASES*NUM_LANES-1:0] PHASE_LANES = 15'b10000_00101_01010,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALL_RED_CYCLES = 1,
  localparam int PW = NUM_PHASES > 1 ? $clog2(NUM_PHASES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] sensor,
  output colors                lights [NUM_LANES],
  output logic [PW-1:0]        active_phase,
  output logic                 phase_green
);
  localparam int CMAX = GREEN_MAX > YELLOW_CYCLES ?
    (GREEN_MAX > ALL_RED_CYCLES ? GREEN_MAX : ALL_RED_CYCLES) :
    (YELLOW_CYCLES > ALL_RED_CYCLES ? YELLOW_CYCLES : ALL_RED_CYCLES);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_GREEN = 2'd1, S_YELLOW = 2'd2, S_CLEAR = 2'd3;

  logic [1:0] state, state_nx;
  logic [PW-1:0] rr_ptr, rr_nx, act_nx, base, pick;
  logic [CW-1:0] cnt, cnt_nx;
  logic [NUM_LANES-1:0] req, pend, mask, lit;
  logic [NUM_PHASES-1:0] dem;
  logic own_dem, other_dem, leave, yel_done, clr_done, arb;

  assign mask = PHASE_LANES[active_phase * NUM_LANES +: NUM_LANES];
  assign lit = state == S_GREEN ? mask : '0;
  assign pend = req | sensor;
  assign phase_green = state == S_GREEN;

  always_comb
    for (int p = 0; p < NUM_PHASES; p++)
      dem[p] = |(pend & PHASE_LANES[p * NUM_LANES +: NUM_LANES]);

  assign own_dem = |(pend & mask);
  assign other_dem = |(dem & ~(NUM_PHASES'(1) << active_phase));
  assign leave = (cnt >= CW'(GREEN_MIN) && !own_dem) || (cnt >= CW'(GREEN_MAX) && other_dem);
  assign yel_done = state == S_YELLOW && cnt >= CW'(YELLOW_CYCLES);
  assign clr_done = state == S_CLEAR && cnt >= CW'(ALL_RED_CYCLES);
  assign arb = state == S_IDLE || clr_done || (yel_done && ALL_RED_CYCLES == 0);
  // after a service the scan starts just past the served phase, so it ranks last
  assign base = state == S_IDLE ? rr_ptr :
                active_phase == PW'(NUM_PHASES - 1) ? '0 : active_phase + 1'b1;

  // lowest demanding index at or above base wins, else the lowest one overall (wrap)
  always_comb begin
    pick = base;
    for (int j = NUM_PHASES - 1; j >= 0; j--)
      if (dem[j]) pick = PW'(j);
    for (int j = NUM_PHASES - 1; j >= 0; j--)
      if (dem[j] && j >= int'(base)) pick = PW'(j);
  end

  always_comb begin
    state_nx = state;
    act_nx = active_phase;
    rr_nx = rr_ptr;
    cnt_nx = cnt + 1'b1;
    if (arb) begin
      rr_nx = base;
      state_nx = |dem ? S_GREEN : S_IDLE;
      act_nx = |dem ? pick : active_phase;
      cnt_nx = |dem ? CW'(1) : '0;
    end else if (state == S_GREEN) begin
      state_nx = leave ? S_YELLOW : S_GREEN;
      cnt_nx = leave ? CW'(1) : cnt < CW'(GREEN_MAX) ? cnt + 1'b1 : cnt;
    end else if (yel_done) begin
      state_nx = S_CLEAR;
      cnt_nx = CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      active_phase <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      req <= '0;
    end else begin
      state <= state_nx;
      active_phase <= act_nx;
      rr_ptr <= rr_nx;
      cnt <= cnt_nx;
      req <= pend & ~lit;
    end

  always_comb
    for (int i = 0; i < NUM_LANES; i++)
      lights[i] = !mask[i] ? RED : state == S_GREEN ? GREEN : state == S_YELLOW ? YELLOW : RED;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: randomized and directed stimulus scored against a countdown-based reference model
module tb_traffic_phase_controller;
  import light_package::*;
  localparam int NL = 5, NP = 3, GMIN = 5, GMAX = 10, YEL = 2, ALLRED = 1;
  localparam logic [NP*NL-1:0] PL = 15'b10000_00101_01010;

  typedef struct {
    logic [2*NL-1:0] lights;
    int              phase;
    bit              green;
  } exp_t;

  logic clk = 0, reset = 1;
  logic [NL-1:0] sensor = '0;
  colors lights [NL];
  logic [1:0] active_phase;
  logic phase_green;

  exp_t sb [$];
  int n_vec = 0, n_bad = 0;
  // model: m_green = green age (0 when not green), m_yel / m_red = cycles left in yellow / all-red
  bit [NL-1:0] m_req;
  int m_phase = 0, m_ptr = 0, m_green = 0, m_yel = 0, m_red = 0;

  traffic_phase_controller dut (
    .clk(clk), .reset(reset), .sensor(sensor),
    .lights(lights), .active_phase(active_phase), .phase_green(phase_green)
  );

  always #5 clk = ~clk;

  function automatic int mask_of(int p);
    return int'(PL >> (p * NL)) & ((1 << NL) - 1);
  endfunction

  function automatic void serve(int start, int dem);
    int idx;
    m_ptr = start;
    for (int k = 0; k < NP; k++) begin
      idx = (start + k) % NP;
      if (m_green == 0 && ((dem >> idx) & 1) != 0) begin
        m_phase = idx;
        m_green = 1;
      end
    end
  endfunction

  function automatic void model_step(bit [NL-1:0] s, bit r);
    int pend, lit, dem;
    bit own, other;
    if (r) begin
      m_req = '0;
      m_phase = 0;
      m_ptr = 0;
      m_green = 0;
      m_yel = 0;
      m_red = 0;
    end else begin
      lit = m_green > 0 ? mask_of(m_phase) : 0;
      pend = int'(m_req | s);
      dem = 0;
      other = 0;
      for (int p = 0; p < NP; p++)
        if ((pend & mask_of(p)) != 0) begin
          dem |= 1 << p;
          if (p != m_phase) other = 1;
        end
      own = (pend & mask_of(m_phase)) != 0;
      m_req = NL'(pend & ~lit);
      if (m_green > 0) begin
        if ((m_green >= GMIN && !own) || (m_green >= GMAX && other)) begin
          m_green = 0;
          m_yel = YEL;
        end else m_green++;
      end else if (m_yel > 0) begin
        m_yel--;
        if (m_yel == 0) begin
          if (ALLRED > 0) m_red = ALLRED;
          else serve((m_phase + 1) % NP, dem);
        end
      end else if (m_red > 0) begin
        m_red--;
        if (m_red == 0) serve((m_phase + 1) % NP, dem);
      end else serve(m_ptr, dem);
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int mk;
    mk = mask_of(m_phase);
    e.lights = '0;
    for (int i = 0; i < NL; i++)
      if (((mk >> i) & 1) != 0)
        e.lights[2*i +: 2] = m_green > 0 ? GREEN : m_yel > 0 ? YELLOW : RED;
    e.phase = m_phase;
    e.green = m_green > 0;
    return e;
  endfunction

  task automatic check_red();
    bit bad;
    bad = phase_green !== 1'b0 || active_phase !== 2'd0;
    for (int i = 0; i < NL; i++) if (lights[i] != RED) bad = 1;
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL async_reset t=%0t phase_green=%b active_phase=%0d, required all red, 0, 0",
               $time, phase_green, active_phase);
    end
  endtask

  // s is held across the edge; g is a glitch that ends before the edge
  task automatic cycle(input bit [NL-1:0] s, input bit r, input bit [NL-1:0] g);
    @(negedge clk);
    #1;
    if (r && !reset) begin
      reset = 1;
      sensor = s | g;
      #1;
      check_red();
    end
    reset = r;
    sensor = s | g;
    #2;
    sensor = s;
    @(posedge clk);
    model_step(s, r);
    sb.push_back(model_out());
  endtask

  task automatic run(input bit [NL-1:0] s, input int n);
    for (int k = 0; k < n; k++) cycle(s, 1'b0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [2*NL-1:0] got;
    int mk;
    bit unsafe;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < NL; i++) got[2*i +: 2] = lights[i];
        n_vec++;
        if (got !== e.lights || int'(active_phase) != e.phase || phase_green !== e.green) begin
          n_bad++;
          $display("FAIL outputs t=%0t lights=%b phase=%0d green=%b, required lights=%b phase=%0d green=%b",
                   $time, got, active_phase, phase_green, e.lights, e.phase, e.green);
        end
        mk = mask_of(int'(active_phase));
        unsafe = 0;
        for (int i = 0; i < NL; i++)
          if (((mk >> i) & 1) == 0 && lights[i] != RED) unsafe = 1;
        n_vec++;
        if (unsafe) begin
          n_bad++;
          $display("FAIL invariant t=%0t lights=%b phase=%0d, required red outside mask %b",
                   $time, got, active_phase, NL'(mk));
        end
      end
    end
  end

  initial begin : driver
    bit [NL-1:0] pat, s, g;
    bit r;
    cycle(5'h1f, 1'b1, '0);
    cycle(5'h1f, 1'b1, '0);
    run(5'h1f, 3);
    run(5'h00, 30);
    run(5'b10000, 1);
    run(5'h00, 12);
    run(5'b10000, 20);
    run(5'b10010, 20);
    run(5'h00, 25);
    run(5'h1f, 60);
    run(5'h00, 25);
    run(5'b00001, 3);
    run(5'h00, 15);
    cycle(5'h00, 1'b0, 5'b10000);
    run(5'h00, 3);
    run(5'b10000, 1);
    run(5'h00, 6);
    cycle(5'h00, 1'b1, '0);
    cycle(5'h00, 1'b1, '0);
    run(5'b10000, 1);
    run(5'h00, 15);
    pat = '0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) pat = NL'($urandom) & NL'($urandom);
      s = pat | (NL'($urandom) & NL'($urandom) & NL'($urandom));
      g = $urandom_range(0, 9) == 0 ? NL'($urandom) : '0;
      r = $urandom_range(0, 149) == 0;
      cycle(s, r, g);
    end
    run(5'h00, 30);
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised successor to the two-way and five-lane traffic light controllers. It drives NUM_LANES signal heads grouped into NUM_PHASES mutually compatible phases, with four additions:
- latched lane requests, so short sensor pulses are not lost;
- minimum-green, gap-out and maximum-green timing;
- a programmable all-red clearance;
- round-robin service among competing phases.

It sits between the intersection sensor inputs and the light drivers, and uses the `colors` enum from light_package.

## Interface
- NUM_LANES, 5: number of lanes. Default order: 0=e_str, 1=e_left, 2=w_str, 3=w_left, 4=ns.
- NUM_PHASES, 3: number of phases.
- PHASE_LANES, 15'b10000_00101_01010: NUM_PHASES×NUM_LANES lane-membership masks, phase p at bits [p*NUM_LANES +: NUM_LANES]. Default masks: phase0={e_left,w_left}, phase1={e_str,w_str}, phase2={ns}.
- GREEN_MIN, 5: minimum green cycles, ≥1.
- GREEN_MAX, 10: maximum green cycles while a conflicting demand exists, ≥GREEN_MIN.
- YELLOW_CYCLES, 2: yellow duration, ≥1.
- ALL_RED_CYCLES, 1: clearance between phases, ≥0.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; forces all-red.
- sensor  in  NUM_LANES  per-lane vehicle presence.
- lights  out  colors[NUM_LANES]  per-lane head (red/yellow/green).
- active_phase  out  $clog2(NUM_PHASES)  phase currently or most recently served.
- phase_green  out  1  high while in GREEN.

## Operation
- **Lane requests:** req[i] is set on any edge where sensor[i]=1 and lane i is not green. req[i] is cleared on any edge where lane i is green.
- **Phase demand:** dem[p] = |((req | sensor) & mask[p]).
- **IDLE (reset state):**
  - All lights red.
  - If any dem, select the first demanding phase scanning from rr_ptr upward (wraps), then go to GREEN with green_cnt=1.
- **GREEN:** lanes in mask[active_phase] are green; all others are red. green_cnt increments each cycle. Exit to YELLOW when any of these holds:
  - green_cnt ≥ GREEN_MIN and own demand is gone (gap-out);
  - green_cnt ≥ GREEN_MAX and another phase demands (max-out).
  - With own demand present and no other demand, green holds indefinitely.
- **YELLOW:** the same lanes show yellow for YELLOW_CYCLES cycles, then the block enters CLEAR.
- **CLEAR:** all red for ALL_RED_CYCLES cycles (the state is skipped if the parameter is 0). Then rr_ptr = active_phase+1 (mod NUM_PHASES), and the block arbitrates as in IDLE.
  - The just-served phase has lowest priority.
  - If only that phase demands, it is served again.
  - With no demand, the block goes to IDLE.
- **Overlapping masks:** a lane may appear in several masks. It is lit whenever it is in the active phase's mask.
- **Safety invariant:** every lane outside mask[active_phase] is red in all states.
- **Reset:**
  - Asserting reset immediately forces all lights red, state IDLE, req=0, rr_ptr=0, active_phase=0, phase_green=0, and all counters to 0.
  - Reset may arrive mid-GREEN, mid-YELLOW or mid-CLEAR; the result is the same.

## Timing
- Moore outputs: lights, active_phase and phase_green are decoded from registered state and change only after a clk edge or on reset.
- **Request-to-green latency:** a sensor high at edge k while the block is in IDLE gives green after edge k. Latency through CLEAR is governed by the counters above.
- **Sampling:** a sensor pulse covering one rising edge is latched and served. A pulse covering no edge is ignored.
- **Durations** are exact counts of clock periods:
  - green: ≥GREEN_MIN;
  - yellow: YELLOW_CYCLES;
  - all-red: ALL_RED_CYCLES.
- **Simultaneous demand:** phases demanding on the same edge are ordered by rr_ptr. From reset the service order is phase0, phase1, phase2, phase0, and so on.
- **Late conflicting demand:** if a conflicting demand first appears when green_cnt is already ≥GREEN_MAX, YELLOW starts after the next edge.

## Test plan
1. **Reset:** hold reset 2 cycles with all sensors high → all 5 lights red, active_phase=0, phase_green=0. Release → phase0 lanes (e_left, w_left) go green on the first edge.
2. **Short NS pulse:** from IDLE, ns sensor high for 1 edge only → ns green exactly 5 cycles, yellow 2, red 1, then IDLE with all red.
3. **Max-out:** ns held high alone for 20 cycles → ns stays green. Then e_left rises → ns yellow starts after the next edge and lasts 2 cycles, then 1 all-red cycle, then e_left green while e_str/ns stay red.
4. **Round-robin:** all five sensors high together from IDLE → left phase green 10, yellow 2, all-red 1; then straight phase 10/2/1; then ns 10/2/1; then the left phase again. The invariant holds on every cycle.
5. **Gap-out:** e_str held 3 cycles, w_str idle → straight phase green exactly GREEN_MIN=5 cycles; w_str head is green together with e_str.
6. **Reset mid-yellow:** assert reset mid-yellow → lights red immediately, without waiting for an edge. Release with ns only high → ns green after the first edge, rr_ptr restarted at phase 0.
